// File: rtl/rob_idx_alloc.sv
// rob_idx_alloc: owner of the ROB head/tail pointers.
// Pointers are robIdx_t = {flipped, idx}; all arithmetic is modulo 2^PW, so the
// flipped bit toggles naturally whenever idx wraps ROB_SIZE-1 -> 0.
//
// Handshake: dispatch holds i_alloc_valid/i_alloc_num; an allocation happens on
// a clock edge where i_alloc_valid && o_alloc_ready && !i_squash. o_alloc_ready
// depends only on registered state and i_alloc_num (never on i_alloc_valid or
// same-cycle commit), and o_alloc_idx is valid in the same cycle it is granted.
module rob_idx_alloc #(
  parameter int ROB_SIZE     = 128,
  parameter int ALLOC_WIDTH  = 4,
  parameter int COMMIT_WIDTH = 4,
  localparam int IW = $clog2(ROB_SIZE),
  localparam int PW = IW + 1,
  localparam int NW = $clog2(ALLOC_WIDTH + 1),
  localparam int CW = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_alloc_valid,
  input  logic [NW-1:0]             i_alloc_num,
  output logic                      o_alloc_ready,
  output logic [ALLOC_WIDTH*PW-1:0] o_alloc_idx,
  input  logic [CW-1:0]             i_commit_num,
  input  logic                      i_squash,
  input  logic [PW-1:0]             i_squash_idx,
  output logic [PW-1:0]             o_head,
  output logic [PW-1:0]             o_tail,
  output logic [PW-1:0]             o_count,
  output logic                      o_empty,
  output logic                      o_full,
  output logic                      o_err
);

  localparam logic [PW-1:0] ROB_SIZE_P = PW'(ROB_SIZE);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          err_q, err_d;

  logic [PW-1:0] count;
  logic [PW-1:0] free_cnt;
  logic [PW-1:0] alloc_ext;
  logic [PW-1:0] commit_ext;
  logic [PW-1:0] commit_eff;
  logic [PW-1:0] head_next;
  logic [PW-1:0] sq_dist;
  logic [PW-1:0] live_dist;
  logic          commit_over;
  logic          squash_ok;
  logic          alloc_ready;
  logic          alloc_fire;

  // Occupancy, readiness, clipped commit and squash range check.
  always_comb begin
    count       = tail_q - head_q;
    free_cnt    = ROB_SIZE_P - count;
    alloc_ext   = PW'(i_alloc_num);
    commit_ext  = PW'(i_commit_num);
    alloc_ready = free_cnt >= alloc_ext;
    alloc_fire  = i_alloc_valid & alloc_ready & ~i_squash;
    // Retiring more than is live is a protocol error; retire only what exists.
    commit_over = commit_ext > count;
    commit_eff  = commit_over ? count : commit_ext;
    head_next   = head_q + commit_eff;
    // A squash target is legal only if it lies within [head_next, tail].
    sq_dist     = i_squash_idx - head_next;
    live_dist   = tail_q - head_next;
    squash_ok   = sq_dist <= live_dist;
  end

  // Next pointers: commit always applies; squash overrides allocation.
  always_comb begin
    head_d = head_next;
    tail_d = tail_q;
    err_d  = err_q | commit_over;
    if (i_squash) begin
      if (squash_ok) tail_d = i_squash_idx;
      else           err_d  = 1'b1;
    end else if (alloc_fire) begin
      tail_d = tail_q + alloc_ext;
    end
  end

  // Pointer and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  // Slot k always shows tail+k, requested or not.
  for (genvar k = 0; k < ALLOC_WIDTH; k++) begin : g_slot
    assign o_alloc_idx[k*PW +: PW] = tail_q + PW'(k);
  end

  assign o_alloc_ready = alloc_ready;
  assign o_head        = head_q;
  assign o_tail        = tail_q;
  assign o_count       = count;
  assign o_empty       = head_q == tail_q;
  assign o_full        = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
  assign o_err         = err_q;

  // Consecutive allocation slots.
  for (genvar k = 0; k < ALLOC_WIDTH - 1; k++) begin : g_slot_chk
    a_slot_consec: assert property (@(posedge clk) disable iff (!rst)
      o_alloc_idx[(k+1)*PW +: PW] == o_alloc_idx[k*PW +: PW] + PW'(1));
  end

  // Head only moves forward: a flipped-bit change must come with an idx wrap.
  a_head_flip: assert property (@(posedge clk) disable iff (!rst)
    (head_d[IW] != head_q[IW]) |-> (head_d[IW-1:0] < head_q[IW-1:0]));

  // Tail forward on allocation: flip only on wrap past ROB_SIZE-1.
  a_tail_flip_alloc: assert property (@(posedge clk) disable iff (!rst)
    (alloc_fire && (tail_d[IW] != tail_q[IW])) |-> (tail_d[IW-1:0] < tail_q[IW-1:0]));

  // Tail backward on squash: flip only when rolling back across idx 0.
  a_tail_flip_squash: assert property (@(posedge clk) disable iff (!rst)
    (i_squash && squash_ok && (tail_d[IW] != tail_q[IW])) |-> (tail_d[IW-1:0] >= tail_q[IW-1:0]));

  // Occupancy bound.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count <= ROB_SIZE_P);

endmodule

// File: tb/tb_rob_idx_alloc.sv
// Directed bench for rob_idx_alloc with an expected-value queue.
module tb_rob_idx_alloc;

  localparam int ROB_SIZE = 128;
  localparam int AW       = 4;
  localparam int PW       = 8;
  localparam int NW       = 3;
  localparam int CNW      = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            alloc_valid;
  logic [NW-1:0]   alloc_num;
  logic            alloc_ready;
  logic [AW*PW-1:0] alloc_idx;
  logic [CNW-1:0]  commit_num;
  logic            squash;
  logic [PW-1:0]   squash_idx;
  logic [PW-1:0]   head, tail, count;
  logic            empty, full, err;

  logic [PW-1:0]   exp_q[$];
  logic [PW-1:0]   e;
  logic [PW-1:0]   m_tail;
  int              checks   = 0;
  int              failures = 0;

  rob_idx_alloc #(.ROB_SIZE(ROB_SIZE), .ALLOC_WIDTH(AW), .COMMIT_WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_alloc_valid (alloc_valid),
    .i_alloc_num   (alloc_num),
    .o_alloc_ready (alloc_ready),
    .o_alloc_idx   (alloc_idx),
    .i_commit_num  (commit_num),
    .i_squash      (squash),
    .i_squash_idx  (squash_idx),
    .o_head        (head),
    .o_tail        (tail),
    .o_count       (count),
    .o_empty       (empty),
    .o_full        (full),
    .o_err         (err)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [NW-1:0] n, input logic [CNW-1:0] c,
                       input logic s, input logic [PW-1:0] si);
    alloc_valid = v;
    alloc_num   = n;
    commit_num  = c;
    squash      = s;
    squash_idx  = si;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, '0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    m_tail = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd0);
    exp_q.push_back(8'd1); exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    e = exp_q.pop_front(); checks++;
    if (head !== e) begin failures++; $display("FAIL rst_head got=%0d exp=%0d", head, e); end
    e = exp_q.pop_front(); checks++;
    if (tail !== e) begin failures++; $display("FAIL rst_tail got=%0d exp=%0d", tail, e); end
    e = exp_q.pop_front(); checks++;
    if (count !== e) begin failures++; $display("FAIL rst_count got=%0d exp=%0d", count, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(empty) !== e) begin failures++; $display("FAIL rst_empty got=%0d exp=%0d", empty, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(full) !== e) begin failures++; $display("FAIL rst_full got=%0d exp=%0d", full, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(err) !== e) begin failures++; $display("FAIL rst_err got=%0d exp=%0d", err, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(alloc_ready) !== e) begin failures++; $display("FAIL rst_ready got=%0d exp=%0d", alloc_ready, e); end
    rst = 1'b1;
    m_tail = '0;
  endtask

  task automatic test_fill();
    for (int c = 0; c < 32; c++) begin
      drive(1'b1, 3'd4, '0, 1'b0, '0);
      for (int k = 0; k < AW; k++) exp_q.push_back(m_tail + PW'(k));
      for (int k = 0; k < AW; k++) begin
        e = exp_q.pop_front(); checks++;
        if (alloc_idx[k*PW +: PW] !== e) begin
          failures++; $display("FAIL fill_slot%0d cyc=%0d got=%0h exp=%0h", k, c, alloc_idx[k*PW +: PW], e);
        end
      end
      checks++;
      if (alloc_ready !== 1'b1) begin failures++; $display("FAIL fill_ready cyc=%0d got=%0d exp=1", c, alloc_ready); end
      tick();
      m_tail = m_tail + 8'd4;
    end
    drive(1'b0, 3'd1, '0, 1'b0, '0);
    exp_q.push_back(8'd1); exp_q.push_back(8'h80); exp_q.push_back(8'h80);
    exp_q.push_back(8'h00); exp_q.push_back(8'd0); exp_q.push_back(8'd0);
    e = exp_q.pop_front(); checks++;
    if (PW'(full) !== e) begin failures++; $display("FAIL full_flag got=%0d exp=%0d", full, e); end
    e = exp_q.pop_front(); checks++;
    if (count !== e) begin failures++; $display("FAIL full_count got=%0h exp=%0h", count, e); end
    e = exp_q.pop_front(); checks++;
    if (tail !== e) begin failures++; $display("FAIL full_tail got=%0h exp=%0h", tail, e); end
    e = exp_q.pop_front(); checks++;
    if (head !== e) begin failures++; $display("FAIL full_head got=%0h exp=%0h", head, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(alloc_ready) !== e) begin failures++; $display("FAIL full_ready got=%0d exp=%0d", alloc_ready, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(empty) !== e) begin failures++; $display("FAIL full_empty got=%0d exp=%0d", empty, e); end
  endtask

  task automatic test_commit_from_full();
    drive(1'b1, 3'd4, 3'd4, 1'b0, '0);
    checks++;
    if (alloc_ready !== 1'b0) begin failures++; $display("FAIL cff_ready_same got=%0d exp=0", alloc_ready); end
    tick();
    drive(1'b1, 3'd4, 3'd0, 1'b0, '0);
    exp_q.push_back(8'd1); exp_q.push_back(8'd124); exp_q.push_back(8'd4); exp_q.push_back(8'h80);
    e = exp_q.pop_front(); checks++;
    if (PW'(alloc_ready) !== e) begin failures++; $display("FAIL cff_ready_next got=%0d exp=%0d", alloc_ready, e); end
    e = exp_q.pop_front(); checks++;
    if (count !== e) begin failures++; $display("FAIL cff_count got=%0d exp=%0d", count, e); end
    e = exp_q.pop_front(); checks++;
    if (head !== e) begin failures++; $display("FAIL cff_head got=%0d exp=%0d", head, e); end
    e = exp_q.pop_front(); checks++;
    if (tail !== e) begin failures++; $display("FAIL cff_tail got=%0h exp=%0h", tail, e); end
    drive(1'b0, 3'd0, 3'd0, 1'b0, '0);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 31; c++) begin drive(1'b1, 3'd4, '0, 1'b0, '0); tick(); end
    drive(1'b1, 3'd2, '0, 1'b0, '0); tick();
    for (int c = 0; c < 30; c++) begin drive(1'b0, 3'd0, 3'd4, 1'b0, '0); tick(); end
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    checks++;
    if (head !== 8'd120 || tail !== 8'd126) begin
      failures++; $display("FAIL wrap_setup got=%0d/%0d exp=120/126", head, tail);
    end
    drive(1'b1, 3'd4, '0, 1'b0, '0);
    exp_q.push_back(8'h7E); exp_q.push_back(8'h7F); exp_q.push_back(8'h80); exp_q.push_back(8'h81);
    for (int k = 0; k < AW; k++) begin
      e = exp_q.pop_front(); checks++;
      if (alloc_idx[k*PW +: PW] !== e) begin
        failures++; $display("FAIL wrap_slot%0d got=%0h exp=%0h", k, alloc_idx[k*PW +: PW], e);
      end
    end
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    exp_q.push_back(8'h82); exp_q.push_back(8'd10); exp_q.push_back(8'd120);
    e = exp_q.pop_front(); checks++;
    if (tail !== e) begin failures++; $display("FAIL wrap_tail got=%0h exp=%0h", tail, e); end
    e = exp_q.pop_front(); checks++;
    if (count !== e) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", count, e); end
    e = exp_q.pop_front(); checks++;
    if (head !== e) begin failures++; $display("FAIL wrap_head got=%0d exp=%0d", head, e); end
  endtask

  task automatic test_squash_with_alloc();
    drive(1'b1, 3'd3, 3'd2, 1'b1, 8'd124);
    exp_q.push_back(8'd122); exp_q.push_back(8'd124); exp_q.push_back(8'd2); exp_q.push_back(8'd0);
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    e = exp_q.pop_front(); checks++;
    if (head !== e) begin failures++; $display("FAIL sq_head got=%0d exp=%0d", head, e); end
    e = exp_q.pop_front(); checks++;
    if (tail !== e) begin failures++; $display("FAIL sq_tail got=%0h exp=%0h", tail, e); end
    e = exp_q.pop_front(); checks++;
    if (count !== e) begin failures++; $display("FAIL sq_count got=%0d exp=%0d", count, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(err) !== e) begin failures++; $display("FAIL sq_err got=%0d exp=%0d", err, e); end
  endtask

  task automatic test_squash_noop();
    drive(1'b0, 3'd0, '0, 1'b1, 8'd124);
    exp_q.push_back(8'd124); exp_q.push_back(8'd0);
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    e = exp_q.pop_front(); checks++;
    if (tail !== e) begin failures++; $display("FAIL sqnop_tail got=%0d exp=%0d", tail, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(err) !== e) begin failures++; $display("FAIL sqnop_err got=%0d exp=%0d", err, e); end
  endtask

  task automatic test_commit_overflow();
    drive(1'b0, 3'd0, 3'd1, 1'b0, '0);
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    checks++;
    if (head !== 8'd123 || count !== 8'd1) begin
      failures++; $display("FAIL ovf_setup got=%0d/%0d exp=123/1", head, count);
    end
    drive(1'b0, 3'd0, 3'd3, 1'b0, '0);
    exp_q.push_back(8'd124); exp_q.push_back(8'd1); exp_q.push_back(8'd1);
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    e = exp_q.pop_front(); checks++;
    if (head !== e) begin failures++; $display("FAIL ovf_head got=%0d exp=%0d", head, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(empty) !== e) begin failures++; $display("FAIL ovf_empty got=%0d exp=%0d", empty, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(err) !== e) begin failures++; $display("FAIL ovf_err got=%0d exp=%0d", err, e); end
    repeat (3) tick();
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL ovf_err_sticky got=%0d exp=1", err); end
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c < 12; c++) begin drive(1'b1, 3'd4, '0, 1'b0, '0); tick(); end
    drive(1'b1, 3'd2, '0, 1'b0, '0); tick();
    drive(1'b1, 3'd4, 3'd2, 1'b0, '0);
    checks++;
    if (count !== 8'd50) begin failures++; $display("FAIL mid_setup_count got=%0d exp=50", count); end
    rst = 1'b0;
    #1;
    exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    e = exp_q.pop_front(); checks++;
    if (head !== e) begin failures++; $display("FAIL mid_head got=%0d exp=%0d", head, e); end
    e = exp_q.pop_front(); checks++;
    if (tail !== e) begin failures++; $display("FAIL mid_tail got=%0d exp=%0d", tail, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(empty) !== e) begin failures++; $display("FAIL mid_empty got=%0d exp=%0d", empty, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(err) !== e) begin failures++; $display("FAIL mid_err got=%0d exp=%0d", err, e); end
    tick();
    checks++;
    if (tail !== 8'd0 || head !== 8'd0) begin
      failures++; $display("FAIL mid_hold got=%0d/%0d exp=0/0", head, tail);
    end
    rst = 1'b1;
    drive(1'b1, 3'd1, '0, 1'b0, '0);
    exp_q.push_back(8'd0);
    e = exp_q.pop_front(); checks++;
    if (alloc_idx[PW-1:0] !== e) begin failures++; $display("FAIL mid_first_idx got=%0h exp=%0h", alloc_idx[PW-1:0], e); end
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    checks++;
    if (tail !== 8'd1) begin failures++; $display("FAIL mid_after_tail got=%0d exp=1", tail); end
  endtask

  task automatic test_commit_squash_empty();
    drive(1'b1, 3'd3, '0, 1'b0, '0); tick();
    drive(1'b0, 3'd0, 3'd4, 1'b1, 8'd4);
    exp_q.push_back(8'd4); exp_q.push_back(8'd4); exp_q.push_back(8'd1);
    exp_q.push_back(8'd0); exp_q.push_back(8'd0);
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    e = exp_q.pop_front(); checks++;
    if (head !== e) begin failures++; $display("FAIL cse_head got=%0d exp=%0d", head, e); end
    e = exp_q.pop_front(); checks++;
    if (tail !== e) begin failures++; $display("FAIL cse_tail got=%0d exp=%0d", tail, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(empty) !== e) begin failures++; $display("FAIL cse_empty got=%0d exp=%0d", empty, e); end
    e = exp_q.pop_front(); checks++;
    if (count !== e) begin failures++; $display("FAIL cse_count got=%0d exp=%0d", count, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(err) !== e) begin failures++; $display("FAIL cse_err got=%0d exp=%0d", err, e); end
  endtask

  task automatic test_squash_illegal();
    drive(1'b1, 3'd4, '0, 1'b0, '0); tick();
    drive(1'b1, 3'd2, '0, 1'b1, 8'd2);
    exp_q.push_back(8'd8); exp_q.push_back(8'd4); exp_q.push_back(8'd1);
    tick();
    drive(1'b0, 3'd0, '0, 1'b0, '0);
    e = exp_q.pop_front(); checks++;
    if (tail !== e) begin failures++; $display("FAIL sqill_tail got=%0d exp=%0d", tail, e); end
    e = exp_q.pop_front(); checks++;
    if (head !== e) begin failures++; $display("FAIL sqill_head got=%0d exp=%0d", head, e); end
    e = exp_q.pop_front(); checks++;
    if (PW'(err) !== e) begin failures++; $display("FAIL sqill_err got=%0d exp=%0d", err, e); end
  endtask

  initial begin
    alloc_valid = 1'b0;
    alloc_num   = '0;
    commit_num  = '0;
    squash      = 1'b0;
    squash_idx  = '0;
    m_tail      = '0;
    test_reset();
    test_fill();
    test_commit_from_full();
    test_wrap();
    test_squash_with_alloc();
    test_squash_noop();
    test_commit_overflow();
    test_reset_mid_burst();
    test_commit_squash_empty();
    test_squash_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_idx_alloc.md
Name: rob_idx_alloc

Overview:
Owns the ROB head/tail pointers, encoded as robIdx_t ({flipped, idx}). It hands out consecutive ROB indices to rename/dispatch and retires them at commit. It also rolls the tail back on a pipeline squash. Every other unit treats robIdx_t as read-only; this block is the single place those values are created and advanced.

Parameters:
ROB_SIZE, 128, number of ROB entries; must be a power of two. Pointer width PW = $clog2(ROB_SIZE)+1, including the flipped bit.
ALLOC_WIDTH, 4, maximum indices allocated per cycle.
COMMIT_WIDTH, 4, maximum entries retired per cycle.

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-low
i_alloc_valid  in  1  dispatch requests allocation this cycle
i_alloc_num  in  $clog2(ALLOC_WIDTH+1)  number of indices requested (0..ALLOC_WIDTH)
o_alloc_ready  out  1  free entries >= i_alloc_num
o_alloc_idx  out  ALLOC_WIDTH x PW  robIdx_t for slot k = tail+k (wrapped)
i_commit_num  in  $clog2(COMMIT_WIDTH+1)  entries retired this cycle
i_squash  in  1  squash younger instructions
i_squash_idx  in  PW  robIdx_t that becomes the new tail (first freed entry)
o_head  out  PW  oldest live entry
o_tail  out  PW  next entry to allocate
o_count  out  PW  live entries (0..ROB_SIZE)
o_empty  out  1  o_count==0
o_full  out  1  o_count==ROB_SIZE
o_err  out  1  sticky protocol-violation flag

Behaviour:
- Pointer arithmetic is modulo 2^PW. The idx field wraps ROB_SIZE-1 -> 0 and toggles flipped on that wrap.
- count = tail - head, computed in PW bits.
- Full: idx fields equal and flipped bits differ.
- Empty: both pointers fully equal.
- Reset (rst low, asynchronous): head=0, tail=0, o_count=0, o_empty=1, o_full=0, o_err=0, o_alloc_ready=1 (when i_alloc_num=0).
- o_alloc_idx slot k = tail+k for all k, whether or not the slot is requested.
- Outputs are combinational from registered pointers. Zero-cycle latency: an index is usable in the same cycle it is granted.
- Alloc fire = i_alloc_valid & o_alloc_ready & !i_squash. On fire, tail += i_alloc_num.
- o_alloc_ready = (ROB_SIZE - count) >= i_alloc_num. It is independent of same-cycle commit; freed entries become visible the next cycle.
- Commit: head += i_commit_num.
  - If i_commit_num > count, head advances by count only and o_err is set.
  - Commit is always applied, including in squash cycles.
- Squash has priority over allocation; allocation that cycle is dropped. tail <= i_squash_idx.
  - Legal range: i_squash_idx - head_next <= tail - head_next, where head_next is the post-commit head.
  - Out of range: tail is unchanged and o_err is set.
  - i_squash_idx == tail is legal and is a no-op.
  - i_squash_idx == head_next empties the ROB.
- Simultaneous commit-to-empty and squash-to-head_next: ROB ends empty, and head==tail including the flipped bit.
- o_err clears only on reset.
- Reset mid-operation: all state returns to reset values immediately. In-flight requests in that cycle have no effect.
- Assertions:
  - o_alloc_idx slots are consecutive.
  - The flipped bit never toggles except on idx wrap.
  - o_count never exceeds ROB_SIZE.

Test Plan:
- Reset, then alloc 4/cycle for 32 cycles with no commit -> o_full=1, o_alloc_ready=0 for i_alloc_num=1, tail={1,0}, head={0,0}.
- From full, commit 4 in one cycle while requesting 4 -> o_alloc_ready=0 that cycle. Next cycle ready=1, count=124.
- Wrap: head={0,120}, tail={0,126}, alloc 4 -> o_alloc_idx = {0,126},{0,127},{1,0},{1,1}; new tail={1,2}, count=10.
- Squash with i_squash_idx={0,124}, tail={1,2}, head={0,120}, plus same-cycle alloc 3 and commit 2 -> alloc ignored, head={0,122}, tail={0,124}, count=2, o_err=0.
- Illegal cases:
  - i_squash_idx={0,100} with head={0,120} -> tail unchanged, o_err=1.
  - i_commit_num=3 with count=1 -> head advances by 1, o_empty=1, o_err stays 1 until reset.
- Assert rst low mid-burst (count=50) -> same cycle head=tail={0,0}, o_empty=1, o_err=0. After release, first alloc returns {0,0}.
